// File: rtl/mac_layer_engine.sv
// Dense layer engine: streams in x, reads weights per lane group, accumulates
// in full precision, saturates once, applies activation and streams y out.
module mac_layer_engine #(
  parameter int unsigned M          = 8,
  parameter int unsigned N          = 8,
  parameter int unsigned T          = 8,
  parameter int unsigned P          = 2,
  parameter int unsigned ACC_W      = 2*T + $clog2(N),
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [T-1:0]               s_data,
  input  logic [1:0]                 act_mode,
  output logic                       w_rd_en,
  output logic [$clog2(M*N/P)-1:0]   w_addr,
  input  logic [P*T-1:0]             w_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [T-1:0]               m_data,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int unsigned AW = $clog2(M*N/P);
  localparam int unsigned GN = M / P;
  localparam int unsigned GW = (GN > 1) ? $clog2(GN) : 1;
  localparam int unsigned KW = $clog2(N + 1);
  localparam int unsigned XW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = (P > 1) ? $clog2(P) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (T-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_FINAL, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [GW-1:0]             g_q, g_d;
  logic [KW-1:0]             iss_k_q, iss_k_d;
  logic                      rd_d_q;
  logic [XW-1:0]             rd_k_q;
  logic [1:0]                mode_q, mode_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic                      w_rd_en_d;
  logic [AW-1:0]             w_addr_d;
  logic                      m_valid_d;
  logic [T-1:0]              m_data_d;
  logic                      start_grp, final_en, sat_clr;
  logic                      s_fire, m_fire;

  logic signed [T-1:0]       x_buf   [N];
  logic signed [T-1:0]       obuf    [P];
  logic signed [ACC_W-1:0]   acc_q   [P];
  logic signed [2*T-1:0]     prod    [P];
  logic signed [T-1:0]       sat_v   [P];
  logic signed [T-1:0]       fin_res [P];
  logic [P-1:0]              fin_clamp;

  function automatic logic [AW-1:0] addr_of(input logic [GW-1:0] g,
                                            input logic [KW-1:0] k);
    return AW'(32'(g) * N + 32'(k));
  endfunction

  // Input side is only open in LOAD; reset forces it closed immediately.
  assign s_ready = (state_q == S_LOAD) && !reset;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  // Per-lane product, one-shot saturation and activation.
  always_comb begin
    fin_clamp = '0;
    for (int i = 0; i < P; i++) begin
      prod[i] = x_buf[rd_k_q] * $signed(w_data[i*T +: T]);
      if (acc_q[i] > SAT_MAX) begin
        sat_v[i]     = {1'b0, {(T-1){1'b1}}};
        fin_clamp[i] = 1'b1;
      end else if (acc_q[i] < SAT_MIN) begin
        sat_v[i]     = {1'b1, {(T-1){1'b0}}};
        fin_clamp[i] = 1'b1;
      end else begin
        sat_v[i] = T'(acc_q[i]);
      end
      case (mode_q)
        2'd1:    fin_res[i] = (sat_v[i] < 0) ? '0 : sat_v[i];
        2'd2:    fin_res[i] = (sat_v[i] < 0) ? (sat_v[i] >>> LEAK_SHIFT) : sat_v[i];
        default: fin_res[i] = sat_v[i];
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    g_d       = g_q;
    iss_k_d   = iss_k_q;
    mode_d    = mode_q;
    slot_d    = slot_q;
    w_rd_en_d = 1'b0;
    w_addr_d  = w_addr;
    m_valid_d = m_valid;
    m_data_d  = m_data;
    start_grp = 1'b0;
    final_en  = 1'b0;
    sat_clr   = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (s_fire) begin
          k_d     = k_q + KW'(1);
          sat_clr = (k_q == '0);
          if (k_q == KW'(N-1)) begin
            mode_d    = act_mode;
            g_d       = '0;
            k_d       = '0;
            start_grp = 1'b1;
            state_d   = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (iss_k_q != KW'(N)) begin
          w_rd_en_d = 1'b1;
          w_addr_d  = addr_of(g_q, iss_k_q);
          iss_k_d   = iss_k_q + KW'(1);
        end else if (rd_d_q && (rd_k_q == XW'(N-1))) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        final_en  = 1'b1;
        m_valid_d = 1'b1;
        m_data_d  = fin_res[0];
        slot_d    = '0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (m_fire) begin
          if (slot_q == SW'(P-1)) begin
            m_valid_d = 1'b0;
            slot_d    = '0;
            if (g_q != GW'(GN-1)) begin
              g_d       = g_q + GW'(1);
              start_grp = 1'b1;
              state_d   = S_MAC;
            end else begin
              k_d     = '0;
              state_d = S_LOAD;
            end
          end else begin
            slot_d   = slot_q + SW'(1);
            m_data_d = obuf[slot_q + SW'(1)];
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    // A group starts by issuing its k = 0 read on the very next cycle.
    if (start_grp) begin
      w_rd_en_d = 1'b1;
      w_addr_d  = addr_of(g_d, '0);
      iss_k_d   = KW'(1);
    end
  end

  // Control state, outputs and accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      k_q      <= '0;
      g_q      <= '0;
      iss_k_q  <= '0;
      rd_d_q   <= 1'b0;
      rd_k_q   <= '0;
      mode_q   <= '0;
      slot_q   <= '0;
      w_rd_en  <= 1'b0;
      w_addr   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      busy     <= 1'b0;
      sat_flag <= 1'b0;
      for (int i = 0; i < P; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      iss_k_q <= iss_k_d;
      rd_d_q  <= w_rd_en;
      rd_k_q  <= XW'(iss_k_q - KW'(1));
      mode_q  <= mode_d;
      slot_q  <= slot_d;
      w_rd_en <= w_rd_en_d;
      w_addr  <= w_addr_d;
      m_valid <= m_valid_d;
      m_data  <= m_data_d;
      busy    <= (state_d != S_LOAD);
      if (sat_clr)
        sat_flag <= 1'b0;
      else if (final_en && (|fin_clamp))
        sat_flag <= 1'b1;
      for (int i = 0; i < P; i++) begin
        if (start_grp)
          acc_q[i] <= '0;
        else if (rd_d_q)
          acc_q[i] <= acc_q[i] + ACC_W'(prod[i]);
      end
    end
  end

  // Vector and result storage carry no reset.
  always_ff @(posedge clk) begin
    if (s_fire)
      x_buf[XW'(k_q)] <= s_data;
    if (!reset && final_en)
      for (int i = 0; i < P; i++) obuf[i] <= fin_res[i];
  end

endmodule

// File: tb/tb_mac_layer_engine.sv
// Directed bench for mac_layer_engine: identity, saturation, activations,
// output backpressure, mid-run reset and input-side gating.
module tb_mac_layer_engine;

  localparam int M  = 8;
  localparam int N  = 8;
  localparam int T  = 8;
  localparam int P  = 2;
  localparam int AW = $clog2(M*N/P);

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [T-1:0]  s_data;
  logic [1:0]    act_mode;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [P*T-1:0] w_data;
  logic          m_valid;
  logic          m_ready;
  logic [T-1:0]  m_data;
  logic          busy;
  logic          sat_flag;

  int total = 0;
  int bad   = 0;
  int wrom [M][N];
  int xv    [N];
  int exp_y [M];
  int got_y [$];
  int lat;

  mac_layer_engine #(.M(M), .N(N), .T(T), .P(P), .LEAK_SHIFT(3)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .act_mode(act_mode),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Weight ROM with one cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en)
      for (int i = 0; i < P; i++)
        w_data[i*T +: T] <= T'(wrom[(int'(w_addr) / N) * P + i][int'(w_addr) % N]);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_w(input int kind, input int v);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0:       wrom[r][c] = (r == c) ? 1 : 0;
          1:       wrom[r][c] = v;
          default: wrom[r][c] = (r < 2) ? 1 : 0;
        endcase
  endtask

  task automatic set_x(input int a0, input int a1, input int a2, input int a3,
                       input int a4, input int a5, input int a6, input int a7);
    xv[0] = a0; xv[1] = a1; xv[2] = a2; xv[3] = a3;
    xv[4] = a4; xv[5] = a5; xv[6] = a6; xv[7] = a7;
  endtask

  task automatic set_exp_rows01(input int v01);
    for (int r = 0; r < M; r++) exp_y[r] = (r < 2) ? v01 : 0;
  endtask

  task automatic send_vec(input int mode, input bit gaps, input bit chk_clr);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    bit  clr_done = 0;
    while (k < N && cyc < 300) begin
      @(negedge clk);
      if (chk_clr && k == 1 && !clr_done) begin
        check("sat_clear_on_first_word", int'(sat_flag), 0);
        clr_done = 1;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = T'(xv[k]);
      end
      act_mode = 2'(mode);
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) k++;
      cyc++;
    end
    if (k < N) check("load_timeout", k, N);
  endtask

  task automatic collect(input int n, input int bp, input bit hold, output int first_lat);
    int   edges = 0;
    int   got = 0;
    int   stray = 0;
    int   stall_left = 0;
    bit   stall_done = 0;
    bit   stalled = 0;
    logic [T-1:0] prev = '0;
    first_lat = -1;
    got_y.delete();
    while (got < n && edges < 2000) begin
      @(negedge clk);
      if (m_valid && first_lat < 0) first_lat = edges;
      if (stalled) begin
        check("stall_data_stable", int'(m_data), int'(prev));
        check("stall_valid_held", int'(m_valid), 1);
      end
      s_valid = hold;
      s_data  = 8'h55;
      if (s_valid && s_ready) stray++;
      if (bp == 0) begin
        m_ready = 1'b1;
      end else if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (got == 1 && !stall_done && m_valid) begin
        stall_done = 1;
        stall_left = 19;
        m_ready    = 1'b0;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      if (m_valid && m_ready) begin
        got_y.push_back(int'($signed(m_data)));
        got++;
      end
      stalled = m_valid && !m_ready;
      prev    = m_data;
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("result_count", got, n);
    check("stray_accept", stray, 0);
  endtask

  task automatic compare(input string name, input int n);
    for (int i = 0; i < n && i < got_y.size(); i++)
      check($sformatf("%s_y%0d", name, i), got_y[i], exp_y[i]);
  endtask

  task automatic run(input string name, input int mode, input bit gaps,
                     input bit hold, input int bp);
    send_vec(mode, gaps, 1'b0);
    collect(M, bp, hold, lat);
    compare(name, M);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; act_mode = '0; m_ready = 1'b0;
    w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_w_rd_en", int'(w_rd_en), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_s_ready", int'(s_ready), 0);
    reset = 1'b0;
    #1;
    check("post_rst_s_ready", int'(s_ready), 1);

    // Identity weights pass x through, first result N+2 edges after last word.
    set_w(0, 0);
    set_x(5, -3, 127, -128, 0, 1, 2, -1);
    for (int i = 0; i < M; i++) exp_y[i] = xv[i];
    send_vec(0, 1'b0, 1'b0);
    collect(M, 0, 1'b0, lat);
    check("first_latency", lat, N + 2);
    compare("ident", M);
    check("ident_sat", int'(sat_flag), 0);
    check("idle_busy", int'(busy), 0);

    // Positive and negative clamping, with input gaps and s_valid held high.
    set_w(1, 127);
    set_x(127, 127, 127, 127, 127, 127, 127, 127);
    for (int i = 0; i < M; i++) exp_y[i] = 127;
    run("satpos", 0, 1'b1, 1'b1, 0);
    check("satpos_flag", int'(sat_flag), 1);

    set_w(1, -128);
    for (int i = 0; i < M; i++) exp_y[i] = -128;
    send_vec(0, 1'b0, 1'b1);
    collect(M, 0, 1'b1, lat);
    compare("satneg", M);
    check("satneg_flag", int'(sat_flag), 1);

    // Activations at the bottom of the range.
    set_w(2, 0);
    set_x(-16, -16, -16, -16, -16, -16, -16, -16);
    set_exp_rows01(-128); run("act0", 0, 1'b0, 1'b0, 0);
    check("act0_sat", int'(sat_flag), 0);
    set_exp_rows01(0);    run("act1", 1, 1'b0, 1'b0, 0);
    set_exp_rows01(-16);  run("act2", 2, 1'b0, 1'b0, 0);
    set_exp_rows01(-128); run("act3", 3, 1'b0, 1'b0, 0);
    set_x(3, 3, 3, 3, 3, 3, 3, 3);
    set_exp_rows01(24);   run("leakpos", 2, 1'b0, 1'b0, 0);
    set_x(-9, 0, 0, 0, 0, 0, 0, 0);
    set_exp_rows01(-2);   run("leakfloor", 2, 1'b0, 1'b0, 0);

    // Output backpressure including a long stall mid-group.
    set_w(0, 0);
    set_x(10, 20, -30, 40, -50, 60, -70, 80);
    for (int i = 0; i < M; i++) exp_y[i] = xv[i];
    run("bp", 0, 1'b1, 1'b0, 1);

    // Reset during group 2 discards it; a fresh vector runs cleanly.
    set_x(11, 12, 13, 14, 15, 16, 17, 18);
    for (int i = 0; i < M; i++) exp_y[i] = xv[i];
    send_vec(0, 1'b0, 1'b0);
    collect(4, 0, 1'b0, lat);
    compare("pre_rst", 4);
    check("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_w_rd_en", int'(w_rd_en), 0);
    check("midrst_s_ready", int'(s_ready), 0);
    reset = 1'b0;
    #1;
    check("midrst_release_s_ready", int'(s_ready), 1);
    set_x(1, -2, 3, -4, 5, -6, 7, -8);
    for (int i = 0; i < M; i++) exp_y[i] = xv[i];
    send_vec(1, 1'b0, 1'b0);
    for (int i = 0; i < M; i++) exp_y[i] = (xv[i] < 0) ? 0 : xv[i];
    collect(M, 0, 1'b0, lat);
    check("fresh_latency", lat, N + 2);
    compare("fresh", M);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_layer_engine.md
Name: mac_layer_engine

Overview:
- Computes one full dense layer, y = act(sat(W·x)), for an M×N signed weight matrix using P parallel MAC lanes.
- Owns its own sequencing: a streaming input load, a weight-ROM read schedule, full-precision accumulation, one final saturation, and a selectable activation.
- Results leave on a valid/ready stream.
- Successor to the single-row saturating MAC datapath; sits between the input vector source and the next layer.

Parameters:
- M, 8, output rows; M mod P must be 0.
- N, 8, input vector length.
- T, 8, data/weight/result width, signed two's complement.
- P, 2, parallel lanes (rows computed concurrently).
- ACC_W, 2*T+$clog2(N), accumulator width; cannot overflow for any input.
- LEAK_SHIFT, 3, arithmetic right-shift used by leaky ReLU.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- s_valid, input, 1, input word valid.
- s_ready, output, 1, engine accepts input word.
- s_data, input, T, signed input element x[k].
- act_mode, input, 2, 0 = none, 1 = ReLU, 2 = leaky ReLU, 3 = treated as 0; sampled when the last input word is accepted.
- w_rd_en, output, 1, weight read strobe.
- w_addr, output, $clog2(M*N/P), weight address = g*N+k.
- w_data, input, P*T, weights W[g*P+i][k] on w_data[i*T +: T]; valid exactly one cycle after w_rd_en.
- m_valid, output, 1, result valid.
- m_ready, input, 1, downstream accepts result.
- m_data, output, T, signed result y[row].
- busy, output, 1, high in every state except LOAD.
- sat_flag, output, 1, sticky: some accumulator saturated for the current vector.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, and takes priority over all other activity.
- Values during and after reset:
  - State = LOAD; group g = 0; load index k = 0.
  - m_valid = 0, m_data = 0, w_rd_en = 0, w_addr = 0, busy = 0, sat_flag = 0.
  - s_ready = 0 while reset is high; s_ready = 1 on the first cycle after reset deasserts.
  - The x buffer is not cleared; its contents are don't-care.
- Reset mid-operation: any in-flight group and any pending outputs are discarded.
- Handshakes: a transfer occurs on a clock edge where valid && ready. Each is observed only on that edge.
- LOAD state:
  - s_ready = 1; each accepted word is written to x[k], and k increments.
  - The first accepted word clears sat_flag.
  - Gaps in s_valid are allowed.
  - On acceptance of word N-1: latch act_mode, set g = 0, go to MAC.
  - Outside LOAD, s_ready = 0 and s_data is ignored.
- MAC state:
  - Issues w_rd_en = 1 with w_addr = g*N+k for k = 0..N-1 on N consecutive cycles; no stalls.
  - One cycle after each issue, lane i performs acc[i] += x[k]*w_data lane i, in full ACC_W signed precision. There is no per-product or per-step saturation.
  - Accumulators clear when the group starts.
  - After the last accumulate, go to FINAL.
- FINAL state (1 cycle), per lane:
  - Saturate: s = acc if it fits in T bits, else 2^(T-1)-1 or -2^(T-1). Any clamp sets sat_flag.
  - Activate, mode 0: s.
  - Activate, mode 1: s<0 → 0, else s.
  - Activate, mode 2: s<0 → s >>> LEAK_SHIFT (floor), else s.
  - Result is registered into output buffer slot i. Go to OUT.
- OUT state:
  - Presents slots 0..P-1 in order as rows g*P+0 .. g*P+P-1.
  - m_data and m_valid stay stable while m_ready = 0.
  - After slot P-1 transfers: if g < M/P-1, then g++ and go to MAC; else go to LOAD with k = 0.
  - Without backpressure: one result per cycle, and m_valid stays high for P consecutive cycles.
- Latency:
  - First m_valid rises N+2 clock edges after the edge accepting input word N-1.
  - Each later group's m_valid rises N+2 edges after the edge transferring the previous group's last result.
- busy is high in MAC, FINAL and OUT.
- sat_flag holds its value after returning to LOAD, until the next vector's first accepted word.

Test Plan:
- Identity W, x = {5,-3,127,-128,0,1,2,-1}, mode 0 → rows 0..7 output exactly x, in order. First m_valid 10 edges after last accept. sat_flag = 0.
- All W = 127, all x = 127 (acc = 129032) → all outputs 127, sat_flag = 1. All W = -128, x = 127 → all outputs -128. Next vector's first accepted word clears sat_flag.
- Row 0 of W all 1, x all -16 (acc = -128): mode 0 → -128; mode 1 → 0; mode 2 → -16. Row 1 all 1, x all 3: mode 2 → 24.
- Random m_ready backpressure (including low for 20 cycles mid-group) → all 8 results delivered once, in order, with m_data stable during stalls. Matches golden model.
- Reset pulsed during MAC of group 2 → m_valid = 0, busy = 0 next cycle, s_ready = 1 after release. A fresh vector then produces correct outputs with no stale data.
- Random s_valid gaps during LOAD, and s_valid held high during MAC/OUT → only N words consumed per vector, none outside LOAD. Repeat with P = 1 and P = 4; results match golden model.
